// File: rtl/biquad_cascade_sched_pkg.sv
// Shared constants, types and helpers for the three-section biquad EQ scheduler.
package eq_pkg;

  localparam int FRAC     = 14;
  localparam int COEF_W   = 16;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 36;
  localparam int NUM_SECT = 3;
  localparam int NUM_TAP  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_STORE,
    ST_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    MAC_HOLD,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_t;

  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Clamp a wide signed value into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7FFF;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/biquad_cascade_sched_if.sv
// Sample stream and status signals between the sample source and the EQ scheduler.
interface biquad_cascade_sched_if;
  import eq_pkg::*;

  logic    sample_valid;
  sample_t sample_in;
  logic    flush;
  sample_t sample_out;
  logic    output_ready;
  logic    busy;
  logic    overrun;

  modport master (
    output sample_valid, sample_in, flush,
    input  sample_out, output_ready, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, flush,
    output sample_out, output_ready, busy, overrun
  );

endinterface

// File: rtl/biquad_cascade_sched_mac.sv
// Shared signed 16x16 multiplier with a clear/accumulate/subtract accumulator,
// followed by the floor shift and 16-bit saturation of the section result.
module biquad_mac #(
  parameter int FRAC  = eq_pkg::FRAC,
  parameter int ACC_W = eq_pkg::ACC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  eq_pkg::mac_op_t op,
  input  eq_pkg::coef_t   coef,
  input  eq_pkg::sample_t data,
  output eq_pkg::sample_t y_sat
);
  import eq_pkg::*;

  logic signed [2*COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_shr;

  assign prod     = (2*COEF_W)'(coef) * (2*COEF_W)'(data);
  assign prod_ext = {{(ACC_W-2*COEF_W){prod[2*COEF_W-1]}}, prod};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      case (op)
        MAC_LOAD: acc <= prod_ext;
        MAC_ADD:  acc <= acc + prod_ext;
        MAC_SUB:  acc <= acc - prod_ext;
        default:  acc <= acc;
      endcase
    end
  end

  // Arithmetic shift floors toward minus infinity; no rounding term is added.
  assign acc_shr = acc >>> FRAC;
  assign y_sat   = sat16({{(64-ACC_W){acc_shr[ACC_W-1]}}, acc_shr});

endmodule

// File: rtl/biquad_cascade_sched.sv
// Time-multiplexed low/mid/high biquad cascade: one MAC walks 5 taps per
// section, 3 sections per sample, with per-section x/y history.
module biquad_cascade_sched #(
  parameter int FRAC  = eq_pkg::FRAC,
  parameter int ACC_W = eq_pkg::ACC_W
) (
  input  logic                         clk,
  input  logic                         reset,
  biquad_cascade_sched_if.slave        bus,
  input  eq_pkg::coef_t                low_b0,  low_b1,  low_b2,  low_a1,  low_a2,
  input  eq_pkg::coef_t                mid_b0,  mid_b1,  mid_b2,  mid_a1,  mid_a2,
  input  eq_pkg::coef_t                high_b0, high_b1, high_b2, high_a1, high_a2
);
  import eq_pkg::*;

  sched_state_t state, state_nxt;
  logic [2:0]   tap;
  logic [1:0]   sect;
  mac_op_t      mac_op;
  coef_t        coefs [NUM_SECT][NUM_TAP];
  coef_t        coef_sel;
  sample_t      data_sel, x_cur, x_in, y_sat, sample_out_q;
  sample_t      x1 [NUM_SECT];
  sample_t      x2 [NUM_SECT];
  sample_t      y1 [NUM_SECT];
  sample_t      y2 [NUM_SECT];
  logic         output_ready_q, overrun_q, flush_pend;
  logic         in_calc, accept, last_tap, last_sect, clear_hist;

  assign in_calc    = (state == ST_MAC) || (state == ST_STORE);
  assign accept     = bus.sample_valid && !in_calc;
  assign last_tap   = (tap == 3'(NUM_TAP - 1));
  assign last_sect  = (sect == 2'(NUM_SECT - 1));
  assign clear_hist = !in_calc && (bus.flush || (state == ST_DONE && flush_pend));
  // Later sections take the freshly stored output of the section before them.
  assign x_cur      = (sect == 2'd0) ? x_in : y1[sect - 2'd1];

  always_comb begin
    coefs[0][0] = low_b0;  coefs[0][1] = low_b1;  coefs[0][2] = low_b2;  coefs[0][3] = low_a1;  coefs[0][4] = low_a2;
    coefs[1][0] = mid_b0;  coefs[1][1] = mid_b1;  coefs[1][2] = mid_b2;  coefs[1][3] = mid_a1;  coefs[1][4] = mid_a2;
    coefs[2][0] = high_b0; coefs[2][1] = high_b1; coefs[2][2] = high_b2; coefs[2][3] = high_a1; coefs[2][4] = high_a2;
    coef_sel    = coefs[sect][tap];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    mac_op    = MAC_HOLD;
    data_sel  = x_cur;
    case (state)
      ST_IDLE: if (bus.sample_valid) state_nxt = ST_MAC;
      ST_MAC: begin
        case (tap)
          3'd0:    begin mac_op = MAC_LOAD; data_sel = x_cur;    end
          3'd1:    begin mac_op = MAC_ADD;  data_sel = x1[sect]; end
          3'd2:    begin mac_op = MAC_ADD;  data_sel = x2[sect]; end
          3'd3:    begin mac_op = MAC_SUB;  data_sel = y1[sect]; end
          default: begin mac_op = MAC_SUB;  data_sel = y2[sect]; end
        endcase
        if (last_tap) state_nxt = ST_STORE;
      end
      ST_STORE: state_nxt = last_sect ? ST_DONE : ST_MAC;
      ST_DONE:  state_nxt = bus.sample_valid ? ST_MAC : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  biquad_mac #(.FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .op    (mac_op),
    .coef  (coef_sel),
    .data  (data_sel),
    .y_sat (y_sat)
  );

  // NOTE: the history is a handful of flops, not a RAM, so it takes the async
  // reset; an aborted sample must leave no stale state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap            <= '0;
      sect           <= '0;
      x_in           <= '0;
      sample_out_q   <= '0;
      output_ready_q <= 1'b0;
      overrun_q      <= 1'b0;
      flush_pend     <= 1'b0;
      for (int i = 0; i < NUM_SECT; i++) begin
        x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
      end
    end else begin
      output_ready_q <= 1'b0;
      overrun_q      <= bus.sample_valid && in_calc;

      if (accept) begin
        x_in <= bus.sample_in;
        tap  <= '0;
        sect <= '0;
      end

      if (state == ST_MAC) tap <= last_tap ? 3'd0 : tap + 3'd1;

      if (state == ST_STORE) begin
        x2[sect] <= x1[sect];
        x1[sect] <= x_cur;
        y2[sect] <= y1[sect];
        y1[sect] <= y_sat;
        sect     <= last_sect ? 2'd0 : sect + 2'd1;
        if (last_sect) begin
          sample_out_q   <= y_sat;
          output_ready_q <= 1'b1;
        end
      end

      // A flush seen mid-sample is deferred to the DONE edge.
      if (in_calc && bus.flush)  flush_pend <= 1'b1;
      else if (state == ST_DONE) flush_pend <= 1'b0;

      if (clear_hist) begin
        for (int i = 0; i < NUM_SECT; i++) begin
          x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
        end
      end
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.output_ready = output_ready_q;
  assign bus.busy         = in_calc;
  assign bus.overrun      = overrun_q;

endmodule
